microwave_ctrl_gen2: RTL and testbench

MICROWAVE_CTRL_GEN2 -- requirements
Module: microwave_ctrl_gen2

---
 rtl/microwave_ctrl_gen2.sv | 154 +++++++++++++++
 tb/tb_microwave_ctrl_gen2.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_ctrl_gen2.sv
// microwave_ctrl_gen2 -- microwave oven cook controller.
//
// Loads a cook time (seconds) and a power level while IDLE, then counts down
// one second per TICK_DIV clocks while cooking.  The magnetron is duty-cycled
// across a window of PWR_LEVELS one-second slots: it is on for the first
// power_reg slots of each window.  Stop or an open door pauses the cook,
// clear aborts it, and reaching zero enters DONE with a one-cycle done pulse.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   startn          active-low start / resume
//   stopn           active-low stop (pause)
//   clrn            active-low clear (abort to IDLE)
//   door_closed     high when the door is closed
//   load            capture time_in / power_in (IDLE only)
//   time_in         cook time in seconds
//   power_in        requested power level (clamped to PWR_LEVELS)
//   mag_on          magnetron enable (registered)
//   state           IDLE=00, COOK=01, PAUSE=10, DONE=11
//   time_left       remaining seconds
//   done            one-cycle pulse on the first cycle in DONE
module microwave_ctrl_gen2 #(
   parameter int unsigned TIME_W     = 12,
   parameter int unsigned PWR_LEVELS = 10,
   parameter int unsigned TICK_DIV   = 100,
   localparam int unsigned PWR_W     = $clog2(PWR_LEVELS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              startn,
   input  logic              stopn,
   input  logic              clrn,
   input  logic              door_closed,
   input  logic              load,
   input  logic [TIME_W-1:0] time_in,
   input  logic [PWR_W-1:0]  power_in,
   output logic              mag_on,
   output logic [1:0]        state,
   output logic [TIME_W-1:0] time_left,
   output logic              done
);

   localparam int unsigned PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [PWR_W-1:0]  PWR_MAX  = PWR_W'(PWR_LEVELS);
   localparam logic [PWR_W-1:0]  SLOT_LAST = PWR_W'(PWR_LEVELS - 1);
   localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_COOK  = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   state_t              state_q, nxt_state;
   logic [TIME_W-1:0]   time_q, nxt_time;
   logic [PWR_W-1:0]    power_q, nxt_power;
   logic [PRE_W-1:0]    pre_q, nxt_pre;
   logic [PWR_W-1:0]    slot_q, nxt_slot;
   logic                halt;
   logic                tick;

   assign halt = !stopn || !door_closed;
   assign tick = (state_q == ST_COOK) && (pre_q == PRE_LAST);

   always_comb begin
      nxt_state = state_q;
      nxt_time  = time_q;
      nxt_power = power_q;
      nxt_pre   = pre_q;
      nxt_slot  = slot_q;
      case (state_q)
         ST_IDLE: begin
            if (!clrn) begin
               nxt_time = '0;
               nxt_pre  = '0;
               nxt_slot = '0;
            end else if (!halt) begin
               if (load) begin
                  nxt_time  = time_in;
                  nxt_power = (power_in > PWR_MAX) ? PWR_MAX : power_in;
               end else if (!startn && time_q != '0) begin
                  nxt_state = ST_COOK;
                  nxt_pre   = '0;
                  nxt_slot  = '0;
               end
            end
         end
         ST_COOK: begin
            if (!clrn) begin
               nxt_state = ST_IDLE;
               nxt_time  = '0;
               nxt_pre   = '0;
               nxt_slot  = '0;
            end else if (tick && time_q == TIME_ONE) begin
               // Completion outranks stop/door-open on the final tick.
               nxt_state = ST_DONE;
               nxt_time  = '0;
               nxt_pre   = '0;
            end else if (halt) begin
               nxt_state = ST_PAUSE;
            end else if (tick) begin
               nxt_pre  = '0;
               nxt_time = (time_q != '0) ? time_q - TIME_ONE : '0;
               nxt_slot = (slot_q >= SLOT_LAST) ? '0 : slot_q + PWR_W'(1);
            end else begin
               nxt_pre = pre_q + PRE_W'(1);
            end
         end
         ST_PAUSE: begin
            if (!clrn) begin
               nxt_state = ST_IDLE;
               nxt_time  = '0;
               nxt_pre   = '0;
               nxt_slot  = '0;
            end else if (!halt && !startn) begin
               nxt_state = ST_COOK;
            end
         end
         ST_DONE: begin
            if (!clrn || !door_closed) begin
               nxt_state = ST_IDLE;
            end
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   // Outputs are registered from next-state values so they line up with state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         time_q  <= '0;
         power_q <= '0;
         pre_q   <= '0;
         slot_q  <= '0;
         mag_on  <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= nxt_state;
         time_q  <= nxt_time;
         power_q <= nxt_power;
         pre_q   <= nxt_pre;
         slot_q  <= nxt_slot;
         mag_on  <= (nxt_state == ST_COOK) && (nxt_slot < nxt_power);
         done    <= (nxt_state == ST_DONE) && (state_q != ST_DONE);
      end
   end

   assign state     = state_q;
   assign time_left = time_q;

endmodule

// File: tb/tb_microwave_ctrl_gen2.sv
// Testbench for microwave_ctrl_gen2 (TIME_W=8, PWR_LEVELS=4, TICK_DIV=4).
// The reference model tracks the cook as "cycles of counting elapsed" and
// derives remaining time and duty slot arithmetically from that count.
module tb_microwave_ctrl_gen2;

   localparam int TW = 8;
   localparam int PL = 4;
   localparam int TD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          startn = 1'b1;
   logic          stopn = 1'b1;
   logic          clrn = 1'b1;
   logic          door_closed = 1'b1;
   logic          load = 1'b0;
   logic [TW-1:0] time_in = '0;
   logic [2:0]    power_in = '0;
   logic          mag_on;
   logic [1:0]    state;
   logic [TW-1:0] time_left;
   logic          done;

   microwave_ctrl_gen2 #(
      .TIME_W(TW),
      .PWR_LEVELS(PL),
      .TICK_DIV(TD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .startn(startn),
      .stopn(stopn),
      .clrn(clrn),
      .door_closed(door_closed),
      .load(load),
      .time_in(time_in),
      .power_in(power_in),
      .mag_on(mag_on),
      .state(state),
      .time_left(time_left),
      .done(done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;

   // model: 0=IDLE 1=COOK 2=PAUSE 3=DONE
   int m_st = 0;
   int m_loaded = 0;
   int m_el = 0;
   int m_pwr = 0;
   int m_done = 0;
   int prev_st;

   int mag_cnt = 0;
   int done_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      logic halt;
      int rem;
      halt = !stopn || !door_closed;
      if (rst) begin
         m_st = 0; m_loaded = 0; m_el = 0; m_pwr = 0; m_done = 0;
      end else begin
         prev_st = m_st;
         case (m_st)
            0: begin
               if (!clrn) m_loaded = 0;
               else if (!halt) begin
                  if (load) begin
                     m_loaded = int'(time_in);
                     m_pwr = (int'(power_in) > PL) ? PL : int'(power_in);
                  end else if (!startn && m_loaded != 0) begin
                     m_st = 1; m_el = 0;
                  end
               end
            end
            1: begin
               rem = m_loaded - m_el / TD;
               if (!clrn) begin
                  m_st = 0; m_loaded = 0; m_el = 0;
               end else if ((m_el % TD) == TD - 1 && rem == 1) begin
                  m_st = 3; m_loaded = 0; m_el = 0;
               end else if (halt) m_st = 2;
               else m_el++;
            end
            2: begin
               if (!clrn) begin
                  m_st = 0; m_loaded = 0; m_el = 0;
               end else if (!halt && !startn) m_st = 1;
            end
            default: begin
               if (!clrn || !door_closed) m_st = 0;
            end
         endcase
         m_done = (m_st == 3 && prev_st != 3) ? 1 : 0;
      end
   endtask

   task automatic step();
      int exp_mag;
      @(posedge clk);
      model_update();
      #1;
      exp_mag = (m_st == 1 && ((m_el / TD) % PL) < m_pwr) ? 1 : 0;
      chk("state", 32'(state), 32'(m_st));
      chk("time_left", 32'(time_left), 32'(m_loaded - m_el / TD));
      chk("mag_on", 32'(mag_on), 32'(exp_mag));
      chk("done", 32'(done), 32'(m_done));
      if (mag_on === 1'b1) mag_cnt++;
      if (done === 1'b1) done_cnt++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input int t, input int p);
      load = 1'b1; time_in = TW'(t); power_in = 3'(p);
      step();
      load = 1'b0;
   endtask

   task automatic do_start();
      startn = 1'b0;
      step();
      startn = 1'b1;
   endtask

   initial begin
      // reset held for two cycles
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_time", 32'(time_left), 32'd0);

      // full-power 3 s cook to DONE
      do_load(3, 4);
      mag_cnt = 0; done_cnt = 0;
      do_start();
      chk("start_cook", 32'(state), 32'd1);
      run(14);
      chk("full_mag_cycles", 32'(mag_cnt), 32'd12);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("in_done", 32'(state), 32'd3);
      // start ignored in DONE, door open leaves
      do_start();
      chk("done_start_ignored", 32'(state), 32'd3);
      door_closed = 1'b0; step(); door_closed = 1'b1;
      chk("done_to_idle", 32'(state), 32'd0);

      // half power duty cycle
      do_load(8, 2);
      mag_cnt = 0;
      do_start();
      run(31);
      chk("half_mag_cycles", 32'(mag_cnt), 32'd16);
      clrn = 1'b0; step(); clrn = 1'b1;

      // clamped power, pause by door at time_left=5, resume
      do_load(7, 7);
      do_start();
      run(8);
      chk("tl_before_pause", 32'(time_left), 32'd5);
      door_closed = 1'b0; step();
      chk("door_pause", 32'(state), 32'd2);
      run(3);
      door_closed = 1'b1;
      chk("pause_hold", 32'(time_left), 32'd5);
      do_start();
      run(12);
      stopn = 1'b0; step(); stopn = 1'b1;
      chk("stop_pause", 32'(state), 32'd2);
      clrn = 1'b0; step(); clrn = 1'b1;
      chk("clear_pause", 32'(time_left), 32'd0);
      do_start();
      chk("start_zero_time", 32'(state), 32'd0);

      // clear and start together in COOK
      do_load(5, 3);
      do_start();
      run(3);
      clrn = 1'b0; startn = 1'b0; step(); clrn = 1'b1; startn = 1'b1;
      chk("clr_beats_start", 32'(state), 32'd0);

      // reset mid-cook
      do_load(9, 1);
      do_start();
      run(6);
      rst = 1'b1; step(); rst = 1'b0;
      chk("rst_midcook", 32'(state), 32'd0);

      // load and start in the same cycle
      load = 1'b1; startn = 1'b0; time_in = 8'd6; power_in = 3'd2;
      step();
      load = 1'b0; startn = 1'b1;
      chk("load_over_start", 32'(time_left), 32'd6);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 199) == 0);
         clrn        = ($urandom_range(0, 49) != 0);
         stopn       = ($urandom_range(0, 19) != 0);
         door_closed = ($urandom_range(0, 19) != 0);
         load        = ($urandom_range(0, 9) == 0);
         startn      = ($urandom_range(0, 5) != 0);
         time_in     = TW'($urandom_range(0, 12));
         power_in    = 3'($urandom_range(0, 7));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
